// File: rtl/fpu_requester.sv
// Initiator side of an FPU rdy/ack operand/result handshake.
// Takes valid/ready commands, returns valid/ready responses, and aborts a stalled FPU on timeout.
module fpu_requester #(
    parameter int unsigned bitness        = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [bitness-1:0]   cmd_a,
    input  logic [bitness-1:0]   cmd_b,
    input  logic [3:0]           cmd_op,
    output logic                 fpu_input_rdy,
    input  logic                 fpu_input_ack,
    output logic [bitness-1:0]   fpu_data_a,
    output logic [bitness-1:0]   fpu_data_b,
    output logic [3:0]           fpu_operation,
    input  logic                 fpu_output_rdy,
    output logic                 fpu_output_ack,
    input  logic [bitness-1:0]   fpu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [bitness-1:0]   rsp_result,
    output logic [3:0]           rsp_op,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] done_count,
    output logic [7:0]           timeout_count
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StAck, StRespond} state_e;

    state_e      state_q, state_d;
    logic [31:0] tmo_q, tmo_d;
    logic        accept, in_hs, out_hs, expire, rsp_hs, counting;

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        accept   = (state_q == StIdle) && cmd_valid;
        in_hs    = (state_q == StIssue) && fpu_input_ack;
        out_hs   = (state_q == StWait) && fpu_output_rdy;
        rsp_hs   = (state_q == StRespond) && rsp_ready;
        counting = (state_q == StIssue) || (state_q == StWait);
        // A handshake on the expiry cycle takes priority over the abort.
        expire   = (TIMEOUT_CYCLES != 0) && counting && !in_hs && !out_hs &&
                   (tmo_q >= 32'(TIMEOUT_CYCLES - 1));

        if (accept) begin
            tmo_d = '0;
        end else if (counting) begin
            tmo_d = tmo_q + 32'd1;
        end

        case (state_q)
            StIdle:    if (accept) state_d = StIssue;
            StIssue:   if (in_hs) state_d = StWait;
            StWait:    if (out_hs) state_d = StAck;
            StAck:     state_d = StRespond;
            StRespond: if (rsp_hs) state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        if (expire) begin
            state_d = StRespond;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            tmo_q          <= '0;
            cmd_ready      <= 1'b1;
            fpu_input_rdy  <= 1'b0;
            fpu_output_ack <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_timeout    <= 1'b0;
            busy           <= 1'b0;
            fpu_data_a     <= '0;
            fpu_data_b     <= '0;
            fpu_operation  <= '0;
            rsp_result     <= '0;
            rsp_op         <= '0;
            done_count     <= '0;
            timeout_count  <= '0;
        end else begin
            state_q        <= state_d;
            tmo_q          <= tmo_d;
            cmd_ready      <= (state_d == StIdle);
            fpu_input_rdy  <= (state_d == StIssue);
            fpu_output_ack <= (state_d == StAck);
            rsp_valid      <= (state_d == StRespond);
            busy           <= (state_d != StIdle);

            if (accept) begin
                fpu_data_a    <= cmd_a;
                fpu_data_b    <= cmd_b;
                fpu_operation <= cmd_op;
                rsp_op        <= cmd_op;
            end
            if (out_hs) begin
                rsp_result <= fpu_result;
            end
            if (expire) begin
                rsp_result  <= '1;
                rsp_timeout <= 1'b1;
            end
            if (rsp_hs) begin
                rsp_timeout <= 1'b0;
                if (rsp_timeout) begin
                    if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
                end else begin
                    done_count <= done_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_requester.sv
// Directed, table-driven bench for fpu_requester with a cycle-level FPU/sink responder.
module tb_fpu_requester;

    localparam int T     = 16;
    localparam int CW    = 4;
    localparam int NEVER = 255;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [31:0]   cmd_a = '0, cmd_b = '0;
    logic [3:0]    cmd_op = '0;
    logic          fpu_input_rdy, fpu_input_ack = 1'b0;
    logic [31:0]   fpu_data_a, fpu_data_b;
    logic [3:0]    fpu_operation;
    logic          fpu_output_rdy = 1'b0, fpu_output_ack;
    logic [31:0]   fpu_result = '0;
    logic          rsp_valid, rsp_ready = 1'b0;
    logic [31:0]   rsp_result;
    logic [3:0]    rsp_op;
    logic          rsp_timeout, busy;
    logic [CW-1:0] done_count;
    logic [7:0]    timeout_count;

    always #5 clock = ~clock;

    fpu_requester #(.bitness(32), .TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .fpu_input_rdy(fpu_input_rdy), .fpu_input_ack(fpu_input_ack),
        .fpu_data_a(fpu_data_a), .fpu_data_b(fpu_data_b), .fpu_operation(fpu_operation),
        .fpu_output_rdy(fpu_output_rdy), .fpu_output_ack(fpu_output_ack),
        .fpu_result(fpu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_timeout(rsp_timeout),
        .busy(busy), .done_count(done_count), .timeout_count(timeout_count)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        int          in_dly;   // extra ISSUE cycles before input_ack
        int          out_dly;  // extra WAIT cycles before output_rdy
        int          rsp_dly;  // cycles rsp_ready is held low
        logic [31:0] res;
        logic        junk;     // drive output_rdy during ISSUE
        logic        exp_tmo;
        int          exp_lat;  // cycle of first rsp_valid, accept edge = 0
    } vec_t;

    int total = 0;
    int bad = 0;
    int exp_done = 0;
    int exp_tcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int   cyc, rdy_cycles, acks, wait_idx, exp_rdy;
        bit   in_wait, ack_now, stable_bad, hold_bad;
        logic [31:0] exp_res;
        exp_res = v.exp_tmo ? 32'hFFFF_FFFF : v.res;
        exp_rdy = (v.in_dly + 1 < T) ? v.in_dly + 1 : T;
        chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_a = v.a; cmd_b = v.b; cmd_op = v.op;
        @(negedge clock);
        cmd_valid = 1'b0; cmd_a = ~v.a; cmd_b = ~v.b; cmd_op = ~v.op;
        cyc = 1; rdy_cycles = 0; acks = 0; wait_idx = 0;
        in_wait = 0; stable_bad = 0; hold_bad = 0;
        while (!rsp_valid && cyc < 100) begin
            fpu_input_ack = 1'b0; fpu_output_rdy = 1'b0; fpu_result = ~v.res;
            ack_now = 0;
            if (cmd_ready || !busy) stable_bad = 1;
            if (fpu_output_ack) acks++;
            if (fpu_input_rdy) begin
                rdy_cycles++;
                if (fpu_data_a !== v.a || fpu_data_b !== v.b || fpu_operation !== v.op)
                    stable_bad = 1;
                if (v.junk) fpu_output_rdy = 1'b1;
                if (rdy_cycles == v.in_dly + 1) begin
                    fpu_input_ack = 1'b1;
                    ack_now = 1;
                end
            end else if (in_wait) begin
                if (wait_idx == v.out_dly) begin
                    fpu_output_rdy = 1'b1;
                    fpu_result = v.res;
                end
                wait_idx++;
            end
            @(negedge clock);
            if (ack_now) in_wait = 1;
            cyc++;
        end
        fpu_input_ack = 1'b0; fpu_output_rdy = 1'b0;
        chk("latency", cyc, v.exp_lat);
        chk("busy_hold", {31'b0, stable_bad}, 32'd0);
        chk("input_rdy_cycles", rdy_cycles, exp_rdy);
        chk("output_ack_pulses", acks, v.exp_tmo ? 32'd0 : 32'd1);
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_op", {28'b0, rsp_op}, {28'b0, v.op});
        chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, v.exp_tmo});
        repeat (v.rsp_dly) begin
            @(negedge clock);
            if (!rsp_valid || rsp_result !== exp_res || rsp_op !== v.op ||
                rsp_timeout !== v.exp_tmo || cmd_ready || fpu_output_ack)
                hold_bad = 1;
        end
        chk("rsp_hold", {31'b0, hold_bad}, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        if (v.exp_tmo) begin
            if (exp_tcnt < 255) exp_tcnt++;
        end else begin
            exp_done++;
        end
        chk("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("post_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("post_busy", {31'b0, busy}, 32'd0);
        chk("post_rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
        chk("done_count", {28'b0, done_count}, exp_done % 16);
        chk("timeout_count", {24'b0, timeout_count}, exp_tcnt);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
        chk({tag, "_input_rdy"}, {31'b0, fpu_input_rdy}, 32'd0);
        chk({tag, "_output_ack"}, {31'b0, fpu_output_ack}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_timeout"}, {31'b0, rsp_timeout}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_data_a"}, fpu_data_a, 32'd0);
        chk({tag, "_data_b"}, fpu_data_b, 32'd0);
        chk({tag, "_operation"}, {28'b0, fpu_operation}, 32'd0);
        chk({tag, "_rsp_result"}, rsp_result, 32'd0);
        chk({tag, "_rsp_op"}, {28'b0, rsp_op}, 32'd0);
        chk({tag, "_done_count"}, {28'b0, done_count}, 32'd0);
        chk({tag, "_timeout_count"}, {24'b0, timeout_count}, 32'd0);
    endtask

    vec_t vecs[7];
    vec_t v_tmo, v_good;

    initial begin
        vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 4'h4, 0, 0, 0, 32'h4040_0000, 1'b0, 1'b0, 4};
        vecs[1] = '{32'h40A0_0000, 32'h3F00_0000, 4'h2, 7, 2, 3, 32'h1234_5678, 1'b1, 1'b0, 13};
        vecs[2] = '{32'h0000_0001, 32'h0000_0002, 4'h7, 1, NEVER, 1, 32'hDEAD_BEEF, 1'b0, 1'b1, 17};
        vecs[3] = '{32'h0000_0005, 32'h0000_0006, 4'h9, 0, 14, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 18};
        vecs[4] = '{32'h0000_0007, 32'h0000_0008, 4'h3, NEVER, 0, 0, 32'h1111_1111, 1'b0, 1'b1, 17};
        vecs[5] = '{32'h0000_0009, 32'h0000_000A, 4'h5, 15, 0, 2, 32'h2222_2222, 1'b1, 1'b0, 19};
        vecs[6] = '{32'hABCD_0000, 32'h0000_1234, 4'hF, 3, 1, 2, 32'h0000_0000, 1'b0, 1'b0, 8};
        v_tmo   = '{32'h1, 32'h1, 4'h1, 0, NEVER, 0, 32'h0, 1'b0, 1'b1, 17};
        v_good  = '{32'h2, 32'h3, 4'h6, 0, 0, 0, 32'h5, 1'b0, 1'b0, 4};

        #2 reset = 1'b0;
        #2 chk_reset_outputs("reset");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // Abandon an operation while in WAIT; reset acts without a clock edge.
        cmd_valid = 1'b1; cmd_a = 32'h7777_0000; cmd_b = 32'h0000_7777; cmd_op = 4'hA;
        @(negedge clock);
        cmd_valid = 1'b0; fpu_input_ack = 1'b1;
        @(negedge clock);
        fpu_input_ack = 1'b0;
        @(negedge clock);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("async");
        exp_done = 0; exp_tcnt = 0;
        @(negedge clock);
        fpu_output_rdy = 1'b1; fpu_result = 32'h5555_5555;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        fpu_output_rdy = 1'b0;
        chk("after_reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("after_reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);

        for (int i = 0; i < 300; i++) run_op(v_tmo);
        chk("tcnt_saturated", {24'b0, timeout_count}, 32'd255);
        chk("done_after_tmo", {28'b0, done_count}, 32'd0);
        for (int i = 0; i < 17; i++) run_op(v_good);
        chk("done_wrapped", {28'b0, done_count}, 32'd1);
        chk("tcnt_still_sat", {24'b0, timeout_count}, 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_requester.md
Name: fpu_requester

Overview:
- Initiator side of the FPU operand/result handshake.
- Accepts operation commands from a valid/ready source and presents operands to an FPU using its rdy/ack handshakes: input_rdy/input_ack for operands, output_rdy/output_ack for the result.
- Collects the result and returns it on a valid/ready response port.
- Adds a per-operation timeout and completion/timeout counters so a stalled FPU cannot hang the datapath.

Parameters:
- bitness, 32, operand/result width; must match the attached FPU.
- TIMEOUT_CYCLES, 1024, cycles allowed in ISSUE+WAIT before abort; 0 disables the timeout.
- CNT_WIDTH, 16, width of done_count.

Ports:
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  requester can accept a command.
- cmd_a  in  bitness  operand A.
- cmd_b  in  bitness  operand B.
- cmd_op  in  4  operation code.
- fpu_input_rdy  out  1  operands valid toward FPU.
- fpu_input_ack  in  1  FPU accepted operands.
- fpu_data_a  out  bitness  registered operand A.
- fpu_data_b  out  bitness  registered operand B.
- fpu_operation  out  4  registered op code.
- fpu_output_rdy  in  1  FPU result valid.
- fpu_output_ack  out  1  result consumed; one-cycle pulse.
- fpu_result  in  bitness  FPU result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  sink accepts response.
- rsp_result  out  bitness  captured result, or all-ones on timeout.
- rsp_op  out  4  op code of this response.
- rsp_timeout  out  1  response is a timeout abort.
- busy  out  1  state != IDLE.
- done_count  out  CNT_WIDTH  non-timeout responses delivered; wraps.
- timeout_count  out  8  timeout responses delivered; saturates at 255.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - cmd_ready=1; fpu_input_rdy=0, fpu_output_ack=0, rsp_valid=0, rsp_timeout=0, busy=0.
  - fpu_data_a, fpu_data_b, fpu_operation, rsp_result, rsp_op = 0; both counters = 0.
  - Reset mid-operation abandons the operation; no response is produced.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, ACK, RESPOND. cmd_ready=1 only in IDLE.
- IDLE: on cmd_valid&&cmd_ready at a posedge:
  - latch cmd_a/cmd_b/cmd_op into fpu_data_a/fpu_data_b/fpu_operation and rsp_op;
  - clear the timeout counter; go to ISSUE.
- ISSUE: fpu_input_rdy=1, with operands held stable.
  - fpu_input_ack=1 sampled at a posedge: go to WAIT; fpu_input_rdy=0 from the next cycle.
- WAIT: fpu_output_rdy=1 sampled at a posedge: capture fpu_result into rsp_result and go to ACK.
- ACK: fpu_output_ack=1 for exactly this one cycle, then go to RESPOND.
- RESPOND: rsp_valid=1; rsp_result/rsp_op/rsp_timeout held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: go to IDLE.
  - Increment done_count if rsp_timeout=0, else timeout_count (saturating).
  - Clear rsp_timeout.
- Timeout counter:
  - Increments each cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT_CYCLES-1 and the state's handshake is not seen that cycle: go to RESPOND with rsp_timeout=1 and rsp_result = all ones.
  - fpu_input_rdy drops immediately; fpu_output_ack is not pulsed.
  - A handshake in the same cycle as expiry wins; no timeout is flagged.
- ACK and RESPOND do not count toward the timeout.
- Minimum latency, with the FPU acking immediately:
  - command accepted at edge 0; ISSUE at cycle 1;
  - WAIT at cycle 2; ACK at cycle 3;
  - rsp_valid at cycle 4.
- Throughput: one operation in flight. The next command is accepted the cycle after the response handshake.
- fpu_result is ignored outside WAIT. fpu_output_rdy seen in ISSUE is ignored.

Test Plan:
1. Reset, then cmd a=0x3F800000, b=0x40000000, op=0x4; responder acks at once and returns 0x40400000 one cycle later → rsp_valid at cycle 4, rsp_result=0x40400000, rsp_op=0x4, rsp_timeout=0, done_count=1, fpu_output_ack high exactly 1 cycle.
2. fpu_input_ack delayed 7 cycles and rsp_ready delayed 3 cycles → fpu_input_rdy high for 8 cycles with fpu_data_a/b stable, response held stable until accepted, cmd_ready=0 throughout.
3. TIMEOUT_CYCLES=16, FPU never asserts fpu_output_rdy → after 16 cycles in ISSUE+WAIT: rsp_timeout=1, rsp_result=0xFFFFFFFF, no fpu_output_ack pulse, timeout_count=1, done_count unchanged.
4. fpu_output_rdy arrives on the exact expiry cycle → normal completion, rsp_timeout=0.
5. Drive reset low while in WAIT → all outputs at reset values asynchronously; after release cmd_ready=1 and no stale rsp_valid.
6. 300 back-to-back timeouts → timeout_count saturates at 255; 65537 good ops → done_count wraps to 1.
